sram_dp_arbiter: RTL

//  Front-end controller for the dual-port synchronous RAM. Shares the write port
//  and the read port each between two requesters with independent round-robin

---
 rtl/sram_ctrl_pkg.sv | 15 +
 rtl/sram_dp_arbiter_rr_arb2.sv | 47 ++++
 rtl/sram_dp_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the dual-port SRAM front-end controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;

    // Controller FSM encoding: SERVE arbitrates requesters, CLEAR zero-fills the RAM
    typedef enum logic {
        ST_SERVE = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/sram_dp_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered favour pointer.
// Latency: grant in the same cycle as the request; pointer moves at the granting edge.
// Backpressure: en low suppresses all grants and freezes the pointer; losers simply wait.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // ptr_q = index of the requester that wins a tie
    logic ptr_q;
    logic ptr_d;

    // Grant: a lone requester wins; on a tie the favoured one wins
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[0] && (!req[1] || !ptr_q)) begin
                gnt[0] = 1'b1;
            end else if (req[1]) begin
                gnt[1] = 1'b1;
            end
        end
    end

    // Next pointer: favour the other requester after any grant, otherwise hold
    always_comb begin
        ptr_d = ptr_q;
        if (gnt[0]) begin
            ptr_d = 1'b1;
        end else if (gnt[1]) begin
            ptr_d = 1'b0;
        end
    end

    // Pointer register; requester 0 is favoured out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sram_dp_arbiter.sv
// Dual-port SRAM front end: round-robin write/read sharing, read return, CLEAR zero-fill.
// Latency: write commits at the grant edge; read data and valid one cycle after the grant.
// Backpressure: ungranted requests are held by the requester; CLEAR blocks all grants.
import sram_ctrl_pkg::*;

module sram_dp_arbiter #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RAM_SIZE   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_req0,
    input  logic [ADDR_WIDTH-1:0] wr_addr0,
    input  logic [DATA_WIDTH-1:0] wr_data0,
    input  logic                  wr_req1,
    input  logic [ADDR_WIDTH-1:0] wr_addr1,
    input  logic [DATA_WIDTH-1:0] wr_data1,
    output logic                  wr_gnt0,
    output logic                  wr_gnt1,
    input  logic                  rd_req0,
    input  logic [ADDR_WIDTH-1:0] rd_addr0,
    input  logic                  rd_req1,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    output logic                  rd_gnt0,
    output logic                  rd_gnt1,
    output logic                  rd_valid0,
    output logic                  rd_valid1,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(RAM_SIZE - 1);

    state_e                  state_q,    state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q,  clr_cnt_d;
    logic                    clr_busy_q, clr_busy_d;
    logic                    clr_done_q, clr_done_d;

    // Read-return stage: per-requester valid tag, collision flag, forwarded write data
    logic [1:0]              rd_vld_q,   rd_vld_d;
    logic                    coll_q,     coll_d;
    logic [DATA_WIDTH-1:0]   fwd_q,      fwd_d;

    logic                    arb_en;
    logic [1:0]              wr_gnt;
    logic [1:0]              rd_gnt;
    logic [ADDR_WIDTH-1:0]   wr_addr_win;
    logic [DATA_WIDTH-1:0]   wr_data_win;
    logic [ADDR_WIDTH-1:0]   rd_addr_win;

    // Grants only in SERVE, never while reset is held, and not on the clr_start cycle
    assign arb_en = rst_n && (state_q == ST_SERVE) && !clr_start;

    rr_arb2 u_wr_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .req   ({wr_req1, wr_req0}),
        .gnt   (wr_gnt)
    );

    rr_arb2 u_rd_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .req   ({rd_req1, rd_req0}),
        .gnt   (rd_gnt)
    );

    assign wr_gnt0 = wr_gnt[0];
    assign wr_gnt1 = wr_gnt[1];
    assign rd_gnt0 = rd_gnt[0];
    assign rd_gnt1 = rd_gnt[1];

    // Winner selection for address/data muxing
    always_comb begin
        wr_addr_win = wr_gnt[1] ? wr_addr1 : wr_addr0;
        wr_data_win = wr_gnt[1] ? wr_data1 : wr_data0;
        rd_addr_win = rd_gnt[1] ? rd_addr1 : rd_addr0;
    end

    // RAM port drive: CLEAR owns the write port, otherwise the granted writer
    always_comb begin
        ram_wr_en   = |wr_gnt;
        ram_wr_addr = wr_addr_win;
        ram_data_in = wr_data_win;
        if (state_q == ST_CLEAR) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = clr_cnt_q;
            ram_data_in = '0;
        end
        ram_rd_en   = |rd_gnt;
        ram_rd_addr = rd_addr_win;
    end

    // FSM next state, clear counter and registered status outputs
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_SERVE: begin
                if (clr_start) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                // clr_start is ignored here; the sweep always runs to the end
                if (clr_cnt_q == CLR_LAST) begin
                    state_d   = ST_SERVE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_SERVE;
                clr_cnt_d = '0;
            end
        endcase
        clr_busy_d = (state_d == ST_CLEAR);
        clr_done_d = (state_d == ST_CLEAR) && (clr_cnt_d == CLR_LAST);
    end

    // FSM registers; reset aborts any CLEAR in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_SERVE;
            clr_cnt_q  <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            clr_busy_q <= clr_busy_d;
            clr_done_q <= clr_done_d;
        end
    end

    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;

    // Read-return capture; a same-address write this cycle is forwarded since the RAM reads old data
    always_comb begin
        rd_vld_d = rd_gnt;
        coll_d   = (|rd_gnt) && (|wr_gnt) && (rd_addr_win == wr_addr_win);
        fwd_d    = wr_data_win;
    end

    // Read-return registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q <= 2'b00;
            coll_q   <= 1'b0;
            fwd_q    <= '0;
        end else begin
            rd_vld_q <= rd_vld_d;
            coll_q   <= coll_d;
            fwd_q    <= fwd_d;
        end
    end

    assign rd_valid0 = rd_vld_q[0];
    assign rd_valid1 = rd_vld_q[1];
    assign rd_data   = (|rd_vld_q) ? (coll_q ? fwd_q : ram_data_out) : '0;

endmodule
